// File: rtl/seq_add_pkg.sv
// seq_add_pkg: shared definitions for the chunked sequential adder.
//   state_t  - controller state encoding (IDLE / RUN / DONE)
//   N_DEF    - default operand width
//   W_DEF    - default chunk adder width
//   NCHUNK   - number of chunks for the default widths
// Optional feature macro used by importers: SEQ_ADD_SUB_EN (subtract support).
package seq_add_pkg;
    localparam int N_DEF  = 32;
    localparam int W_DEF  = 8;
    localparam int NCHUNK = N_DEF / W_DEF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/seq_add_ctrl_if.sv
// seq_add_ctrl_if: request/result bundle of the sequential adder.
//   Request : in_valid, in_ready, a, b, cin, sub (only with SEQ_ADD_SUB_EN)
//   Result  : out_valid, out_ready, sum, cout
//   Status  : busy
// master = requester/consumer side, slave = seq_add_ctrl side.
// Macro: SEQ_ADD_SUB_EN adds the sub signal.
interface seq_add_ctrl_if
    import seq_add_pkg::*;
#(
    parameter int N = N_DEF
) ();
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
`ifdef SEQ_ADD_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         busy;

    modport master (
`ifdef SEQ_ADD_SUB_EN
        output sub,
`endif
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
`ifdef SEQ_ADD_SUB_EN
        input  sub,
`endif
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/seq_add_ctrl_add_chunk.sv
// add_chunk: W-bit combinational ripple-carry adder.
//   a, b : W-bit operands
//   cin  : carry in
//   s    : W-bit sum
//   c    : carry out of bit W-1
module add_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         c
);
    logic [W:0] cy;

    assign cy[0] = cin;

    for (genvar g = 0; g < W; g++) begin : g_bit
        assign s[g]    = a[g] ^ b[g] ^ cy[g];
        assign cy[g+1] = (a[g] & b[g]) | (a[g] & cy[g]) | (b[g] & cy[g]);
    end

    assign c = cy[W];
endmodule

// File: rtl/seq_add_ctrl.sv
// seq_add_ctrl: N-bit adder that processes one W-bit chunk per cycle.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seq_add_ctrl_if.slave (request, result and busy signals)
// A request is accepted in IDLE, the N/W chunks are summed in RUN (LSB chunk
// first), and the result is held in DONE until the consumer takes it.
// Macro: SEQ_ADD_SUB_EN enables a-b via bus.sub (b inverted, carry seed 1).
module seq_add_ctrl
    import seq_add_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input logic           clk,
    input logic           rst_n,
    seq_add_ctrl_if.slave bus
);
    localparam int NCH = N / W;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    state_t       state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic         carry_q, carry_d;
    logic [N-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic         cout_q, cout_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic         busy_q, busy_d;

    logic [W-1:0] ch_a, ch_b, ch_s;
    logic         ch_c;
    logic         last_chunk;

    assign ch_a       = a_q[idx_q*W +: W];
    assign ch_b       = b_q[idx_q*W +: W];
    assign last_chunk = (idx_q == IW'(NCH - 1));

    add_chunk #(.W(W)) u_add_chunk (
        .a   (ch_a),
        .b   (ch_b),
        .cin (carry_q),
        .s   (ch_s),
        .c   (ch_c)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d = bus.a;
`ifdef SEQ_ADD_SUB_EN
                    // Two's complement: a + ~b + 1, cin is ignored.
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
`else
                    b_d     = bus.b;
                    carry_d = bus.cin;
`endif
                    idx_d      = '0;
                    state_d    = S_RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            S_RUN: begin
                sum_d[idx_q*W +: W] = ch_s;
                carry_d             = ch_c;
                if (last_chunk) begin
                    idx_d       = '0;
                    state_d     = S_DONE;
                    cout_d      = ch_c;
                    out_valid_d = 1'b1;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_DONE: begin
                // in_ready rises only after this edge, so an accept can never
                // coincide with the result handshake.
                if (bus.out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                idx_d       = '0;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.busy      = busy_q;
endmodule
